// File: rtl/ecc_point_add_x3y3_if.sv
// Operand/result handshake bundle for ecc_point_add_x3y3; byte 0 of every field is the LSB.
interface ecc_point_add_x3y3_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] l0, l1, l2, l3, l4;
  logic [7:0] x1_0, x1_1, x1_2, x1_3, x1_4;
  logic [7:0] x2_0, x2_1, x2_2, x2_3, x2_4;
  logic [7:0] y1_0, y1_1, y1_2, y1_3, y1_4;
  logic [7:0] a_0, a_1, a_2, a_3, a_4;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] x3_0, x3_1, x3_2, x3_3, x3_4;
  logic [7:0] y3_0, y3_1, y3_2, y3_3, y3_4;

  modport master (
    output in_valid, l0, l1, l2, l3, l4,
           x1_0, x1_1, x1_2, x1_3, x1_4, x2_0, x2_1, x2_2, x2_3, x2_4,
           y1_0, y1_1, y1_2, y1_3, y1_4, a_0, a_1, a_2, a_3, a_4, out_ready,
    input  in_ready, out_valid,
           x3_0, x3_1, x3_2, x3_3, x3_4, y3_0, y3_1, y3_2, y3_3, y3_4
  );

  modport slave (
    input  in_valid, l0, l1, l2, l3, l4,
           x1_0, x1_1, x1_2, x1_3, x1_4, x2_0, x2_1, x2_2, x2_3, x2_4,
           y1_0, y1_1, y1_2, y1_3, y1_4, a_0, a_1, a_2, a_3, a_4, out_ready,
    output in_ready, out_valid,
           x3_0, x3_1, x3_2, x3_3, x3_4, y3_0, y3_1, y3_2, y3_3, y3_4
  );
endinterface

// File: rtl/ecc_point_add_x3y3.sv
// GF(2^40) point-add tail: x3 = L^2+L+x1+x2+a, y3 = L*(x1+x3)+x3+y1, bit-serial multiplier.
// Define ECC_Y3_CALC_EN to build the y3 multiply; otherwise y3 is tied to zero.
module ecc_point_add_x3y3 #(
  parameter logic [39:0] POLY = 40'h00_0000_0039
) (
  input logic                  clk,
  input logic                  reset,
  ecc_point_add_x3y3_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, SQR, X3, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] acc_q, acc_d;
  logic [39:0] l_q, l_d, x1_q, x1_d, x2_q, x2_d, a_q, a_d;
  logic [39:0] x3_q, x3_d;
  logic [39:0] y3_res;
  logic [5:0]  idx;
  logic        mbit;
  logic [39:0] shifted, step;

`ifdef ECC_Y3_CALC_EN
  logic [39:0] y1_q, y1_d, b_q, b_d, y3_q, y3_d;
  assign mbit   = b_q[idx];
  assign y3_res = y3_q;
`else
  assign mbit   = l_q[idx];
  assign y3_res = '0;
`endif

  // One MSB-first shift-and-add step of the serial multiplier.
  assign idx     = 6'd39 - cnt_q;
  assign shifted = {acc_q[38:0], 1'b0} ^ (acc_q[39] ? POLY : '0);
  assign step    = shifted ^ (mbit ? l_q : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    l_d     = l_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    a_d     = a_q;
    x3_d    = x3_q;
`ifdef ECC_Y3_CALC_EN
    y1_d    = y1_q;
    b_d     = b_q;
    y3_d    = y3_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        l_d   = {bus.l4, bus.l3, bus.l2, bus.l1, bus.l0};
        x1_d  = {bus.x1_4, bus.x1_3, bus.x1_2, bus.x1_1, bus.x1_0};
        x2_d  = {bus.x2_4, bus.x2_3, bus.x2_2, bus.x2_1, bus.x2_0};
        a_d   = {bus.a_4, bus.a_3, bus.a_2, bus.a_1, bus.a_0};
`ifdef ECC_Y3_CALC_EN
        y1_d  = {bus.y1_4, bus.y1_3, bus.y1_2, bus.y1_1, bus.y1_0};
        b_d   = {bus.l4, bus.l3, bus.l2, bus.l1, bus.l0};
`endif
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SQR;
      end
      SQR: begin
        acc_d = step;
        if (cnt_q == 6'd39) begin
          cnt_d   = '0;
          state_d = X3;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      X3: begin
        x3_d = acc_q ^ l_q ^ x1_q ^ x2_q ^ a_q;
`ifdef ECC_Y3_CALC_EN
        b_d     = x1_q ^ x3_d;
        acc_d   = '0;
        state_d = MUL;
`else
        state_d = DONE;
`endif
      end
`ifdef ECC_Y3_CALC_EN
      MUL: begin
        acc_d = step;
        if (cnt_q == 6'd39) begin
          cnt_d   = '0;
          y3_d    = step ^ x3_q ^ y1_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      l_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      a_q     <= '0;
      x3_q    <= '0;
`ifdef ECC_Y3_CALC_EN
      y1_q    <= '0;
      b_q     <= '0;
      y3_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      l_q     <= l_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      a_q     <= a_d;
      x3_q    <= x3_d;
`ifdef ECC_Y3_CALC_EN
      y1_q    <= y1_d;
      b_q     <= b_d;
      y3_q    <= y3_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign {bus.x3_4, bus.x3_3, bus.x3_2, bus.x3_1, bus.x3_0} = x3_q;
  assign {bus.y3_4, bus.y3_3, bus.y3_2, bus.y3_1, bus.y3_0} = y3_res;
endmodule

// File: doc/ecc_point_add_x3y3.md
ECC_POINT_ADD_X3Y3 -- requirements
Module: ecc_point_add_x3y3

Interface
REQ-001 Parameter POLY, default 40'h00_0000_0039, low 40 bits of GF(2^40) reduction polynomial x^40+x^5+x^4+x^3+1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  operand set valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 l0..l4  input  8 each  lambda (divider quotient c0..c4); l0 = least significant byte.
REQ-007 x1_0..x1_4, x2_0..x2_4, y1_0..y1_4, a_0..a_4  input  8 each  point/curve operands, byte 0 = LSB.
REQ-008 x3_0..x3_4, y3_0..y3_4  output  8 each  result coordinates, byte 0 = LSB.
REQ-009 out_valid  output  1  results valid.
REQ-010 out_ready  input  1  consumer accepts results.

Function
REQ-011 Block SHALL compute x3 = L^2 + L + x1 + x2 + a and y3 = L*(x1 + x3) + x3 + y1 in GF(2^40) mod POLY (+ is XOR).
REQ-012 FSM states IDLE, SQR, X3, MUL, DONE; in_ready = 1 only in IDLE.
REQ-013 Transfer in IDLE when in_valid=1 (cycle T): all 25 input bytes registered, state -> SQR; inputs ignored until return to IDLE.
REQ-014 SQR: bit-serial MSB-first multiply L*L over 40 cycles (T+1..T+40): acc <= (acc<<1 reduced by POLY) XOR (bit_i ? L : 0), i = 39 down to 0; 6-bit counter.
REQ-015 X3 (T+41): x3 register <= acc ^ L ^ x1 ^ x2 ^ a; state -> MUL.
REQ-016 MUL: L*(x1^x3) bit-serial as REQ-014 over T+42..T+81; then y3 register <= acc ^ x3 ^ y1, state -> DONE.
REQ-017 out_valid = 1 only in DONE, first asserted cycle T+82; x3/y3 stable while out_valid=1.
REQ-018 DONE -> IDLE on cycle with out_ready=1; out_valid held indefinitely while out_ready=0.
REQ-019 Output registers retain last result after handshake until overwritten by next X3/MUL completion.
REQ-020 No overlap: new transfer possible earliest cycle after DONE handshake.
REQ-021 Reduction: shifted-out bit 40 set -> XOR POLY into low 40 bits; all arithmetic exactly 40 bits, no carries.

Reset
REQ-022 reset=0 at a rising edge SHALL force IDLE, counter 0, acc 0, all x3/y3 bytes 0x00, out_valid 0, in_ready 1 next cycle.
REQ-023 reset mid-operation (any state) SHALL abort the operation with no out_valid pulse; reset dominates in_valid/out_ready.

Configuration
REQ-024 Macro ECC_Y3_CALC_EN defined: full behaviour per REQ-011..REQ-018.
REQ-025 Macro undefined: MUL state and its multiply path removed; X3 -> DONE directly, out_valid first at T+42, y3 bytes constant 0x00.

Verification
REQ-026 L=0, x1=5, x2=3, a=1, y1=7 -> x3=0x07, y3=0x00, out_valid at T+82.
REQ-027 L=1, x1=2, x2=4, a=0, y1=0 -> x3=0x06, y3=0x02.
REQ-028 L=2, x1=x2=a=y1=0 -> x3=0x06, y3=0x0A; L=0x10_0000 (x^20), others 0 -> x3=0x10_0039 (reduction check).
REQ-029 out_ready=0 for 10 cycles after out_valid -> out_valid/x3/y3 held, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-030 reset=0 at T+30 with in_valid held -> no out_valid, outputs 0x00, in_ready=1 after reset release; new transfer completes correctly.
REQ-031 Build without ECC_Y3_CALC_EN, vector of REQ-027 -> x3=0x06, y3=0x00, out_valid at T+42.
